// File: rtl/bitwise_logic_pkg.sv
// Shared encodings for the bitwise logic pipe: opcode width and the eight
// operation codes understood by bitwise_logic_core.
package bitwise_logic_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND    = 3'd0;
    localparam op_t OP_OR     = 3'd1;
    localparam op_t OP_XOR    = 3'd2;
    localparam op_t OP_XNOR   = 3'd3;
    localparam op_t OP_NAND   = 3'd4;
    localparam op_t OP_NOR    = 3'd5;
    localparam op_t OP_ANDN   = 3'd6;
    localparam op_t OP_PASS_B = 3'd7;

endpackage

// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result handshake bundle for bitwise_logic_pipe.
// master = producer of operands and consumer of results; slave = the pipe.
interface bitwise_logic_pipe_if
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic             acc_sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, op, acc_sel, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, acc_sel, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/bitwise_logic_core.sv
// Combinational operation stage: (op, op_a, b) -> result_next.
// All operations are carry-free and bitwise over the full width.
module bitwise_logic_core
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_next
);

    // Select the operation; unknown codes fall back to passing B through.
    always_comb begin
        result_next = b;
        case (op)
            OP_AND:    result_next = op_a & b;
            OP_OR:     result_next = op_a | b;
            OP_XOR:    result_next = op_a ^ b;
            OP_XNOR:   result_next = ~(op_a ^ b);
            OP_NAND:   result_next = ~(op_a & b);
            OP_NOR:    result_next = ~(op_a | b);
            OP_ANDN:   result_next = op_a & ~b;
            OP_PASS_B: result_next = b;
            default:   result_next = b;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: one-stage registered bitwise logic unit with valid/ready
// on both sides and an internal accumulator usable as operand A.
// Optional feature macro: LOGIC_STATS_EN enables the accepted-beat counter
// (txn_count); without it txn_count is constant zero and has no flops.
module bitwise_logic_pipe
    import bitwise_logic_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}},
    parameter int               CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                acc_clr,
    bitwise_logic_pipe_if.slave bus,
    output logic [WIDTH-1:0]    acc,
    output logic [CNT_W-1:0]    txn_count
);

    logic             in_ready_s;
    logic             accept_s;
    logic             drain_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] result_next_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic [WIDTH-1:0] acc_r;

    // Ready depends only on local state and the consumer, never on in_valid,
    // so no combinational ready->valid->ready loop can form upstream.
    assign in_ready_s = ena & (~out_valid_r | bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;
    assign drain_s    = out_valid_r & bus.out_ready;
    assign op_a_s     = bus.acc_sel ? acc_r : bus.a;

    bitwise_logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op          (bus.op),
        .op_a        (op_a_s),
        .b           (bus.b),
        .result_next (result_next_s)
    );

    // Result register: load on accept, drop valid on a drain with no new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            result_r    <= result_next_s;
            zero_r      <= ~|result_next_s;
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Accumulator: clear wins over a simultaneous accumulate write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= ACC_INIT;
        end else if (acc_clr) begin
            acc_r <= ACC_INIT;
        end else if (accept_s && bus.acc_sel) begin
            acc_r <= result_next_s;
        end
    end

`ifdef LOGIC_STATS_EN
    logic [CNT_W-1:0] txn_count_r;

    // Accepted-beat counter; wraps modulo 2^CNT_W and ignores acc_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            txn_count_r <= txn_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign txn_count = txn_count_r;
`else
    assign txn_count = {CNT_W{1'b0}};
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign acc           = acc_r;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe (WIDTH=8, ACC_INIT=0, CNT_W=4).
// Directed steps drive beats; a negedge monitor keeps a reference accumulator,
// beat counter and a queue of expected {zero,result} popped on each delivery.
module tb_bitwise_logic_pipe;

    localparam int         W     = 8;
    localparam int         CW    = 4;
    localparam logic [7:0] AINIT = 8'h00;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          acc_clr;
    logic [W-1:0]  acc;
    logic [CW-1:0] txn_count;

    bitwise_logic_pipe_if #(.WIDTH(W)) bus ();

    bitwise_logic_pipe #(
        .WIDTH    (W),
        .ACC_INIT (AINIT),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .acc_clr   (acc_clr),
        .bus       (bus),
        .acc       (acc),
        .txn_count (txn_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0]    exp_q[$];
    logic [7:0]    acc_m;
    logic [CW-1:0] cnt_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x ^ y);
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
            3'd6:    return x & ~y;
            default: return y;
        endcase
    endfunction

    function automatic logic [CW-1:0] cnt_exp(input logic [CW-1:0] c);
`ifdef LOGIC_STATS_EN
        return c;
`else
        return {CW{1'b0}} & c;
`endif
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic       rdy_m;
        logic [7:0] r;
        logic [8:0] e;
        if (!rst_n) begin
            exp_q.delete();
            acc_m = AINIT;
            cnt_m = '0;
        end else begin
            rdy_m = ena & (~bus.out_valid | bus.out_ready);
            chk("in_ready", 32'(bus.in_ready), 32'(rdy_m));
            chk("acc", 32'(acc), 32'(acc_m));
            chk("txn_count", 32'(txn_count), 32'(cnt_exp(cnt_m)));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", 32'(bus.result), 32'(e[7:0]));
                    chk("sb_zero", 32'(bus.zero), 32'(e[8]));
                end
            end
            r = model(bus.op, bus.acc_sel ? acc_m : bus.a, bus.b);
            if (bus.in_valid && rdy_m) begin
                exp_q.push_back({(r == 8'h00), r});
                cnt_m = cnt_m + 1'b1;
            end
            if (acc_clr) acc_m = AINIT;
            else if (bus.in_valid && rdy_m && bus.acc_sel) acc_m = r;
        end
    end

    // Present a beat and hold it until accepted; returns after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic s, output int waits);
        int n;
        n = 0;
        bus.op = o; bus.a = av; bus.b = bv; bus.acc_sel = s; bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'(0));
        waits = n;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tbl[8];
        int w;
        int c0;
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tbl[8];
        int w;
        int c0;
        tbl = '{8'h30, 8'hFC, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'hC0, 8'h3C};
        rst_n = 1'b0; ena = 1'b1; acc_clr = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = 3'd0;
        bus.acc_sel = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_result", 32'(bus.result), 32'(0));
        chk("rst_zero", 32'(bus.zero), 32'(0));
        chk("rst_acc", 32'(acc), 32'(AINIT));
        chk("rst_txn", 32'(txn_count), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: all eight ops back-to-back, one result per cycle, latency 1
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 8'hF0, 8'h3C, 1'b0, w);
            chk("t1_wait", 32'(w), 32'(0));
            chk("t1_valid", 32'(bus.out_valid), 32'(1));
            chk("t1_result", 32'(bus.result), 32'(tbl[i]));
        end
        chk("t1_cycles", 32'(cyc - c0), 32'(8));
        idle(2);

        // 2: backpressure holds the result; release drains and accepts on one edge
        bus.out_ready = 1'b0;
        send(3'd0, 8'hFF, 8'h0F, 1'b0, w);
        bus.op = 3'd1; bus.a = 8'h10; bus.b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_in_ready", 32'(bus.in_ready), 32'(0));
            chk("t2_result", 32'(bus.result), 32'(8'h0F));
            chk("t2_valid", 32'(bus.out_valid), 32'(1));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(3'd1, 8'h10, 8'h01, 1'b0, w);
        chk("t2_same_edge", 32'(w), 32'(0));
        chk("t2_new_result", 32'(bus.result), 32'(8'h11));
        idle(2);

        // 3: accumulate OR chain from a cleared accumulator
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        send(3'd1, 8'hFF, 8'h01, 1'b1, w);
        send(3'd1, 8'hFF, 8'h02, 1'b1, w);
        send(3'd1, 8'hFF, 8'h04, 1'b1, w);
        send(3'd1, 8'hFF, 8'h80, 1'b1, w);
        chk("t3_acc", 32'(acc), 32'(8'h87));
        chk("t3_result", 32'(bus.result), 32'(8'h87));
        chk("t3_zero", 32'(bus.zero), 32'(0));

        // 4: clear collides with an accumulate beat; result uses old acc, clear wins
        acc_clr = 1'b1;
        send(3'd2, 8'h00, 8'h87, 1'b1, w);
        acc_clr = 1'b0;
        chk("t4_result", 32'(bus.result), 32'(8'h00));
        chk("t4_zero", 32'(bus.zero), 32'(1));
        chk("t4_acc", 32'(acc), 32'(AINIT));
        idle(2);

        // 5: ena=0 blocks accepts but a pending result still drains; clear honoured
        bus.out_ready = 1'b0;
        send(3'd7, 8'h00, 8'h5A, 1'b1, w);
        ena = 1'b0; bus.out_ready = 1'b1;
        bus.op = 3'd0; bus.a = 8'hFF; bus.b = 8'hFF; bus.acc_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_in_ready", 32'(bus.in_ready), 32'(0));
            chk("t5_acc", 32'(acc), 32'(8'h5A));
            @(posedge clk); #1;
        end
        chk("t5_drained", 32'(bus.out_valid), 32'(0));
        chk("t5_result_held", 32'(bus.result), 32'(8'h5A));
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        chk("t5_acc_clr", 32'(acc), 32'(AINIT));
        ena = 1'b1;
        idle(2);

        // 6: counter wrap after 17 accepts, then async reset mid-beat
        rst_n = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) send(3'd7, 8'h00, 8'(i), 1'b1, w);
        idle(1);
`ifdef LOGIC_STATS_EN
        chk("t6_txn_wrap", 32'(txn_count), 32'(1));
`else
        chk("t6_txn_tied", 32'(txn_count), 32'(0));
`endif
        chk("t6_acc", 32'(acc), 32'(8'h10));
        bus.out_ready = 1'b0;
        send(3'd5, 8'h00, 8'h00, 1'b0, w);
        chk("t6_pending", 32'(bus.result), 32'(8'hFF));
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.out_valid), 32'(0));
        chk("t6_rst_result", 32'(bus.result), 32'(0));
        chk("t6_rst_zero", 32'(bus.zero), 32'(0));
        chk("t6_rst_acc", 32'(acc), 32'(AINIT));
        chk("t6_rst_txn", 32'(txn_count), 32'(0));
        chk("t6_rst_ready", 32'(bus.in_ready), 32'(1));
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        send(3'd6, 8'hAA, 8'h0F, 1'b0, w);
        chk("t6_post_result", 32'(bus.result), 32'(8'hA0));
        idle(3);
        chk("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
